// File: rtl/dsp48a1_pkg.sv
// dsp48a1_pkg: OPMODE field encodings, idle bubble and result record for the DSP48A1 sequencer
package dsp48a1_pkg;

    localparam logic [1:0] X_ZERO = 2'd0;
    localparam logic [1:0] X_M    = 2'd1;
    localparam logic [1:0] X_P    = 2'd2;
    localparam logic [1:0] X_DAB  = 2'd3;

    localparam logic [1:0] Z_ZERO = 2'd0;
    localparam logic [1:0] Z_PCIN = 2'd1;
    localparam logic [1:0] Z_P    = 2'd2;
    localparam logic [1:0] Z_C    = 2'd3;

    localparam int PREADD_EN = 4;
    localparam int CIN_SEL   = 5;
    localparam int PRESUB    = 6;
    localparam int POSTSUB   = 7;

    // X=0, Z=P, add, no carry: the accumulator keeps its value across idle cycles
    localparam logic [7:0] DEFAULT_IDLE_OPMODE = {4'b0000, Z_P, X_ZERO};

    localparam int RSP_TAG_W = 4;

    typedef enum logic {FLUSH, RUN} seq_state_t;

    typedef struct packed {
        logic [47:0]          p;
        logic                 carryout;
        logic [RSP_TAG_W-1:0] tag;
    } rsp_t;

endpackage

// File: rtl/dsp_rsp_fifo.sv
// dsp_rsp_fifo: in-order result FIFO with occupancy count; same-edge push/pop allowed when full
module dsp_rsp_fifo
    import dsp48a1_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  rsp_t                   din,
    input  logic                   pop,
    output rsp_t                   dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    rsp_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign do_pop = pop && count != '0;
    assign dout   = mem[rd_ptr];

    // Storage, pointers and count; a full FIFO may push only when it pops on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(do_pop);
            assert (!(push && !do_pop && count == CW'(DEPTH)));
        end
    end

endmodule

// File: rtl/dsp48a1_op_sequencer.sv
// dsp48a1_op_sequencer: credit-admitted command issue and in-order result capture for a DSP48A1 slice
module dsp48a1_op_sequencer
    import dsp48a1_pkg::*;
#(
    parameter int         LATENCY     = 4,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         TAG_W       = RSP_TAG_W,
    parameter logic [7:0] IDLE_OPMODE = DEFAULT_IDLE_OPMODE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_opmode,
    input  logic [17:0]      cmd_a,
    input  logic [17:0]      cmd_b,
    input  logic [17:0]      cmd_d,
    input  logic [47:0]      cmd_c,
    input  logic             cmd_carryin,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [17:0]      dsp_d,
    output logic [47:0]      dsp_c,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_carryin,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p,
    input  logic             dsp_carryout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [47:0]      rsp_p,
    output logic             rsp_carryout,
    output logic [TAG_W-1:0] rsp_tag
);

    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int          FW      = $clog2(LATENCY) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

    seq_state_t                    state;
    logic [FW-1:0]                 flush_cnt;
    logic [CW-1:0]                 inflight_cnt;
    logic [CW-1:0]                 fifo_cnt;
    logic [LATENCY-1:0]            vld_sr;
    logic [LATENCY-1:0][TAG_W-1:0] tag_sr;
    logic                          cap_vld;
    logic [TAG_W-1:0]              cap_tag;
    logic                          accept;
    logic                          pop;
    rsp_t                          push_data;
    rsp_t                          head;

    // Credits come from registered counts only, so a pop frees its slot one cycle later
    assign cmd_ready    = state == RUN && ({1'b0, inflight_cnt} + {1'b0, fifo_cnt}) < CREDITS;
    assign accept       = cmd_valid && cmd_ready;
    assign rsp_valid    = fifo_cnt != '0;
    assign pop          = rsp_valid && rsp_ready;
    assign push_data    = '{p: dsp_p, carryout: dsp_carryout, tag: RSP_TAG_W'(cap_tag)};
    assign rsp_p        = head.p;
    assign rsp_carryout = head.carryout;
    assign rsp_tag      = TAG_W'(head.tag);

    // Hold the slice in reset for LATENCY edges after release, then open for commands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FLUSH;
            flush_cnt <= '0;
            dsp_rst   <= 1'b1;
        end else if (state == FLUSH) begin
            flush_cnt <= flush_cnt + 1'b1;
            if (flush_cnt == FW'(LATENCY - 1)) begin
                state   <= RUN;
                dsp_rst <= 1'b0;
            end
        end
    end

    // Present the accepted command to the slice, otherwise a P-preserving bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_a       <= '0;
            dsp_b       <= '0;
            dsp_d       <= '0;
            dsp_c       <= '0;
            dsp_opmode  <= IDLE_OPMODE;
            dsp_carryin <= 1'b0;
        end else begin
            dsp_a       <= accept ? cmd_a : '0;
            dsp_b       <= accept ? cmd_b : '0;
            dsp_d       <= accept ? cmd_d : '0;
            dsp_c       <= accept ? cmd_c : '0;
            dsp_opmode  <= accept ? cmd_opmode : IDLE_OPMODE;
            dsp_carryin <= accept && cmd_carryin;
        end
    end

    // Track each command through the slice pipeline; the capture stage lines up with valid P
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr  <= '0;
            tag_sr  <= '0;
            cap_vld <= 1'b0;
            cap_tag <= '0;
        end else begin
            vld_sr  <= {vld_sr[LATENCY-2:0], accept};
            tag_sr  <= {tag_sr[LATENCY-2:0], cmd_tag};
            cap_vld <= vld_sr[LATENCY-1];
            cap_tag <= tag_sr[LATENCY-1];
        end
    end

    // Commands issued but not yet written into the result FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight_cnt <= '0;
        else inflight_cnt <= inflight_cnt + CW'(accept) - CW'(cap_vld);
    end

    dsp_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cap_vld),
        .din   (push_data),
        .pop   (pop),
        .dout  (head),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_dsp48a1_op_sequencer.sv
// tb_dsp48a1_op_sequencer: directed and random checks of the sequencer against a slice model and a result scoreboard
module tb_dsp48a1_op_sequencer;
    import dsp48a1_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_opmode = '0;
    logic [17:0] cmd_a = '0, cmd_b = '0, cmd_d = '0;
    logic [47:0] cmd_c = '0;
    logic        cmd_carryin = 1'b0;
    logic [3:0]  cmd_tag = '0;
    logic [17:0] dsp_a, dsp_b, dsp_d;
    logic [47:0] dsp_c;
    logic [7:0]  dsp_opmode;
    logic        dsp_carryin, dsp_rst;
    logic [47:0] slice_p;
    logic        slice_co;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [47:0] rsp_p;
    logic        rsp_carryout;
    logic [3:0]  rsp_tag;

    always #5 clk = ~clk;

    dsp48a1_op_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opmode(cmd_opmode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_c(cmd_c),
        .cmd_carryin(cmd_carryin), .cmd_tag(cmd_tag),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
        .dsp_opmode(dsp_opmode), .dsp_carryin(dsp_carryin), .dsp_rst(dsp_rst),
        .dsp_p(slice_p), .dsp_carryout(slice_co),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
        .rsp_carryout(rsp_carryout), .rsp_tag(rsp_tag)
    );

    // One slice operation: optional pre-adder, signed multiply, X/Z muxes, post add/sub with carry
    function automatic logic [48:0] alu(input logic [7:0] op, input logic [17:0] a, b, d,
                                        input logic [47:0] c, input logic ci, input logic [47:0] p);
        logic [17:0] bb;
        logic [35:0] m;
        logic [47:0] x, z;
        bb = op[PREADD_EN] ? (op[PRESUB] ? d - b : d + b) : b;
        m  = {{18{a[17]}}, a} * {{18{bb[17]}}, bb};
        x  = op[1:0] == X_M ? {{12{m[35]}}, m} : op[1:0] == X_P ? p :
             op[1:0] == X_DAB ? {d[11:0], a, b} : 48'd0;
        z  = op[3:2] == Z_C ? c : op[3:2] == Z_P ? p : 48'd0;
        return op[POSTSUB] ? {1'b0, z} - {1'b0, x} - 49'(ci) : {1'b0, z} + {1'b0, x} + 49'(ci);
    endfunction

    // Slice stand-in: operands registered three times, then P register; sync reset from dsp_rst
    typedef struct packed {
        logic [7:0]  op;
        logic [17:0] a, b, d;
        logic [47:0] c;
        logic        ci;
    } sin_t;
    sin_t st [3];

    always @(posedge clk) begin
        if (dsp_rst) begin
            for (int i = 0; i < 3; i++) st[i] <= '0;
            slice_p  <= '0;
            slice_co <= 1'b0;
        end else begin
            st[0] <= '{dsp_opmode, dsp_a, dsp_b, dsp_d, dsp_c, dsp_carryin};
            st[1] <= st[0];
            st[2] <= st[1];
            {slice_co, slice_p} <= alu(st[2].op, st[2].a, st[2].b, st[2].d, st[2].c, st[2].ci, slice_p);
        end
    end

    typedef struct {
        logic [47:0] p;
        logic        co;
        logic [3:0]  tag;
    } exp_t;

    exp_t        sb[$];
    logic [47:0] got_p[$];
    logic [3:0]  got_tag[$];
    logic [47:0] model_p = '0;
    logic        last_acc = 1'b0;
    int          n_chk = 0, n_fail = 0, n_acc = 0, n_pop = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe handshakes before the edge, update the scoreboard, then advance one cycle
    task automatic tick();
        logic [48:0] r;
        exp_t        e;
        last_acc = cmd_valid && cmd_ready;
        if (last_acc) begin
            r = alu(cmd_opmode, cmd_a, cmd_b, cmd_d, cmd_c, cmd_carryin, model_p);
            model_p = r[47:0];
            e = '{r[47:0], r[48], cmd_tag};
            sb.push_back(e);
            n_acc++;
        end
        if (rsp_valid && rsp_ready) begin
            n_pop++;
            got_p.push_back(rsp_p);
            got_tag.push_back(rsp_tag);
            if (sb.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            else begin
                e = sb.pop_front();
                check("rsp_p", 64'(rsp_p), 64'(e.p));
                check("rsp_carryout", 64'(rsp_carryout), 64'(e.co));
                check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] op, input logic [17:0] a, b, input logic [47:0] c, input logic [3:0] tag);
        int g = 0;
        cmd_opmode = op; cmd_a = a; cmd_b = b; cmd_c = c; cmd_d = '0;
        cmd_carryin = 1'b0; cmd_tag = tag; cmd_valid = 1'b1;
        do begin tick(); g++; end while (!last_acc && g < 50);
        cmd_valid = 1'b0;
        check("send_accept", 64'(last_acc), 64'd1);
    endtask

    task automatic drain();
        int g = 0;
        rsp_ready = 1'b1;
        while (sb.size() != 0 && g < 100) begin tick(); g++; end
        check("drain_left", 64'(sb.size()), 64'd0);
    endtask

    task automatic rand_cmd();
        cmd_opmode  = 8'($urandom);
        cmd_a       = 18'($urandom);
        cmd_b       = 18'($urandom);
        cmd_d       = 18'($urandom);
        cmd_c       = {16'($urandom), 32'($urandom)};
        cmd_carryin = 1'($urandom);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog expired");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int a0, p0, sent, g;
        // 1: reset values, FLUSH length
        repeat (3) tick();
        check("rst_dsp_rst", 64'(dsp_rst), 64'd1);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_opmode", 64'(dsp_opmode), 64'h08);
        check("rst_dsp_a", 64'(dsp_a), 64'd0);
        check("rst_rsp_p", 64'({rsp_p, rsp_carryout, rsp_tag}), 64'd0);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("flush_rst_%0d", i), 64'(dsp_rst), 64'd1);
            check($sformatf("flush_ready_%0d", i), 64'(cmd_ready), 64'd0);
        end
        tick();
        check("flush_end_rst", 64'(dsp_rst), 64'd0);
        check("flush_end_ready", 64'(cmd_ready), 64'd1);
        check("flush_rsp_valid", 64'(rsp_valid), 64'd0);

        // 2: single multiply, LATENCY+1 cycle response
        send(8'h01, 18'd3, 18'd5, 48'd0, 4'd7);
        repeat (4) tick();
        check("t2_early", 64'(rsp_valid), 64'd0);
        tick();
        check("t2_valid", 64'(rsp_valid), 64'd1);
        check("t2_p", 64'(rsp_p), 64'd15);
        check("t2_co", 64'(rsp_carryout), 64'd0);
        check("t2_tag", 64'(rsp_tag), 64'd7);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 3: credit limit with consumer stalled
        got_p.delete();
        a0 = n_acc; sent = 0;
        cmd_opmode = 8'h01; cmd_b = 18'd2; cmd_c = '0; cmd_d = '0; cmd_carryin = 1'b0;
        repeat (6) begin
            cmd_valid = sent < 6; cmd_a = 18'(sent + 1); cmd_tag = 4'(sent);
            tick();
            if (last_acc) sent++;
        end
        check("t3_accepted", 64'(n_acc - a0), 64'd4);
        check("t3_ready_low", 64'(cmd_ready), 64'd0);
        rsp_ready = 1'b1; g = 0;
        while (got_p.size() < 6 && g < 100) begin
            cmd_valid = sent < 6; cmd_a = 18'(sent + 1); cmd_tag = 4'(sent);
            tick(); g++;
            if (last_acc) sent++;
        end
        cmd_valid = 1'b0;
        check("t3_count", 64'(got_p.size()), 64'd6);
        for (int i = 0; i < 6 && i < got_p.size(); i++)
            check($sformatf("t3_p%0d", i), 64'(got_p[i]), 64'(2 * (i + 1)));

        // 4: accumulate across idle bubbles
        got_p.delete();
        send(8'h0D, 18'd2, 18'd3, 48'd10, 4'd1);
        repeat (3) tick();
        send(8'h09, 18'd4, 18'd5, 48'd0, 4'd2);
        drain();
        check("t4_count", 64'(got_p.size()), 64'd2);
        if (got_p.size() == 2) begin
            check("t4_first", 64'(got_p[0]), 64'd16);
            check("t4_second", 64'(got_p[1]), 64'd36);
        end

        // 5: random operands, FIFO filled then streamed with consumer ready
        got_tag.delete();
        rsp_ready = 1'b0; sent = 0; g = 0;
        while (sent < 10 && g < 100) begin
            rand_cmd(); cmd_valid = 1'b1; cmd_tag = 4'(sent);
            if (g == 12) rsp_ready = 1'b1;
            tick(); g++;
            if (last_acc) sent++;
        end
        cmd_valid = 1'b0;
        drain();
        check("t5_count", 64'(got_tag.size()), 64'd10);
        for (int i = 0; i < 10 && i < got_tag.size(); i++)
            check($sformatf("t5_tag%0d", i), 64'(got_tag[i]), 64'(i));

        // 5b: random valid/ready traffic
        repeat (80) begin
            rand_cmd(); cmd_tag = 4'($urandom);
            cmd_valid = 1'($urandom); rsp_ready = 1'($urandom);
            tick();
        end
        cmd_valid = 1'b0;
        drain();

        // 6: reset with work in flight and queued
        rsp_ready = 1'b0;
        send(8'h01, 18'd1, 18'd1, 48'd0, 4'd1);
        repeat (5) tick();
        check("t6_queued", 64'(rsp_valid), 64'd1);
        send(8'h01, 18'd2, 18'd2, 48'd0, 4'd2);
        send(8'h01, 18'd3, 18'd3, 48'd0, 4'd3);
        rst_n = 1'b0;
        #1;
        check("t6_rsp_drop", 64'(rsp_valid), 64'd0);
        check("t6_ready_drop", 64'(cmd_ready), 64'd0);
        check("t6_dsp_rst", 64'(dsp_rst), 64'd1);
        sb.delete(); model_p = '0;
        repeat (2) tick();
        rst_n = 1'b1; rsp_ready = 1'b1;
        p0 = n_pop;
        repeat (30) tick();
        check("t6_no_stale", 64'(n_pop - p0), 64'd0);
        check("t6_ready_back", 64'(cmd_ready), 64'd1);
        got_p.delete();
        send(8'h01, 18'd7, 18'd6, 48'd0, 4'd5);
        drain();
        check("t6_count", 64'(got_p.size()), 64'd1);
        if (got_p.size() == 1) check("t6_p", 64'(got_p[0]), 64'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
